// File: rtl/hud_text_ram.sv
// ---------------------------------------------------------------------------
// hud_text_ram
//
// Character buffer for the on-screen HUD text panel. The buffer holds
// DEPTH x 8-bit ASCII cells. The text renderer reads it through a registered
// read port.
//
// The block owns these cells:
//   - the label text ("Score:", "Lives:", "Timer:", "Status:")
//   - the numeric fields (score, lives, timer)
//   - the status field
//
// A sequential refresh engine rewrites the fields whenever the game inputs
// change. It uses an iterative double-dabble BCD converter, so no divide or
// modulo logic is needed. A host write port is kept for free-form text.
//
// Ports:
//   Clk           system clock
//   Reset_n       asynchronous active-low reset
//   score         binary score (SCORE_W bits)
//   counter       binary timer value (TIMER_W bits)
//   lives         lives remaining (4 bits, shown saturated at 9)
//   win, lose     game status flags (win has priority)
//   we            host write enable (has priority over the refresh engine)
//   write_address host write cell
//   data_In       host write data
//   read_address  renderer read cell
//   data_Out      registered read data (1-cycle latency, old data on collision)
//   busy          high while INIT or a refresh is in progress
//
// Build option:
//   HUD_LEADING_BLANK_EN - when defined, leading zero digits of score and
//                          timer are written as 0x00. The least significant
//                          digit is always shown.
// ---------------------------------------------------------------------------
module hud_text_ram #(
    parameter int DEPTH        = 160,
    parameter int SCORE_W      = 10,
    parameter int SCORE_DIGITS = 3,
    parameter int TIMER_W      = 16,
    parameter int TIMER_DIGITS = 3,
    parameter int SCORE_ADDR   = 7,
    parameter int LIVES_ADDR   = 32,
    parameter int TIMER_ADDR   = 87,
    parameter int STATUS_ADDR  = 113,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [SCORE_W-1:0] score,
    input  logic [TIMER_W-1:0] counter,
    input  logic [3:0]         lives,
    input  logic               win,
    input  logic               lose,
    input  logic               we,
    input  logic [AW-1:0]      write_address,
    input  logic [7:0]         data_In,
    input  logic [AW-1:0]      read_address,
    output logic [7:0]         data_Out,
    output logic               busy
);

    localparam int MAXW  = (SCORE_W > TIMER_W) ? SCORE_W : TIMER_W;
    localparam int MAXD  = (SCORE_DIGITS > TIMER_DIGITS) ? SCORE_DIGITS : TIMER_DIGITS;
    localparam int BW    = 4 * MAXD;
    localparam int MAXC1 = (DEPTH > MAXW) ? DEPTH : MAXW;
    localparam int MAXC  = (MAXC1 > 9) ? MAXC1 : 9;
    localparam int CW    = $clog2(MAXC) + 1;
    localparam int SCORE_MAX = (10 ** SCORE_DIGITS) - 1;
    localparam int TIMER_MAX = (10 ** TIMER_DIGITS) - 1;

`ifdef HUD_LEADING_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [47:0] LBL_SCORE  = "Score:";
    localparam logic [47:0] LBL_LIVES  = "Lives:";
    localparam logic [47:0] LBL_TIMER  = "Timer:";
    localparam logic [55:0] LBL_STATUS = "Status:";
    localparam logic [71:0] ST_WON     = {"Game Won", 8'h00};
    localparam logic [71:0] ST_OVER    = "Game Over";
    localparam logic [71:0] ST_PLAY    = {"Play!", 32'h0};

    typedef enum logic [3:0] {
        INIT, IDLE, SNAP, CONV_S, WR_S, CONV_T, WR_T, WR_L, WR_ST
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      idx;
    logic [MAXW-1:0]    shreg;
    logic [BW-1:0]      bcd;
    logic [BW-1:0]      bcd_sh;
    logic [SCORE_W-1:0] snap_score;
    logic [TIMER_W-1:0] snap_counter;
    logic [3:0]         snap_lives;
    logic               snap_win;
    logic               snap_lose;
    logic               lead_seen;
    logic               last;
    logic               int_we;
    logic [AW-1:0]      int_addr;
    logic [7:0]         int_data;
    logic [3:0]         dg;
    logic               dig_nz;
    logic               changed;
    logic               sat_s;
    logic               sat_t;

    logic [7:0] mem [DEPTH];

    // Label text lives in fixed cells just before each field; the cell
    // directly before a field is always 0x00.
    function automatic logic [7:0] label_char(input int a);
        logic [7:0] c;
        c = 8'h00;
        if (a >= SCORE_ADDR - 7 && a <= SCORE_ADDR - 2)
            c = 8'(LBL_SCORE >> (8 * (SCORE_ADDR - 2 - a)));
        else if (a >= LIVES_ADDR - 7 && a <= LIVES_ADDR - 2)
            c = 8'(LBL_LIVES >> (8 * (LIVES_ADDR - 2 - a)));
        else if (a >= TIMER_ADDR - 7 && a <= TIMER_ADDR - 2)
            c = 8'(LBL_TIMER >> (8 * (TIMER_ADDR - 2 - a)));
        else if (a >= STATUS_ADDR - 8 && a <= STATUS_ADDR - 2)
            c = 8'(LBL_STATUS >> (8 * (STATUS_ADDR - 2 - a)));
        return c;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift the
    // next binary bit in. Digits above the displayed count are dropped.
    // Those digits are only needed when the value saturates, and saturation
    // is detected separately from the snapshot.
    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b, input logic bit_in);
        logic [BW-1:0] t;
        logic [3:0]    nib;
        t = b;
        for (int d = 0; d < MAXD; d++) begin
            nib = 4'(t >> (4 * d));
            if (nib >= 4'd5)
                t = t + (BW'(3) << (4 * d));
        end
        return {t[BW-2:0], bit_in};
    endfunction

    function automatic logic [7:0] status_char(input logic w, input logic l, input int i);
        logic [71:0] s;
        if (w)
            s = ST_WON;
        else if (l)
            s = ST_OVER;
        else
            s = ST_PLAY;
        return 8'(s >> (8 * (8 - i)));
    endfunction

    assign changed = ({score, counter, lives, win, lose} !=
                      {snap_score, snap_counter, snap_lives, snap_win, snap_lose});
    assign sat_s   = int'(snap_score)   > SCORE_MAX;
    assign sat_t   = int'(snap_counter) > TIMER_MAX;

    // A host write freezes the whole engine for that cycle. The pending
    // internal write is simply repeated on the next free cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= INIT;
        else if (!we)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        last       = 1'b0;
        int_we     = 1'b0;
        int_addr   = '0;
        int_data   = 8'h00;
        bcd_sh     = '0;
        dg         = 4'h0;
        dig_nz     = 1'b0;
        busy       = 1'b1;
        case (state)
            INIT: begin
                last     = (int'(idx) == DEPTH - 1);
                int_we   = 1'b1;
                int_addr = AW'(idx);
                int_data = label_char(int'(idx));
                if (last)
                    state_next = SNAP;
            end
            IDLE: begin
                busy = 1'b0;
                if (changed)
                    state_next = SNAP;
            end
            SNAP:
                state_next = CONV_S;
            CONV_S: begin
                last = (int'(idx) == SCORE_W - 1);
                if (last)
                    state_next = WR_S;
            end
            WR_S: begin
                last     = (int'(idx) == SCORE_DIGITS - 1);
                bcd_sh   = bcd >> (4 * (SCORE_DIGITS - 1 - int'(idx)));
                dg       = bcd_sh[3:0];
                dig_nz   = sat_s || (dg != 4'h0);
                int_we   = 1'b1;
                int_addr = AW'(SCORE_ADDR + int'(idx));
                if (sat_s)
                    int_data = 8'h39;
                else if (BLANK_EN && !dig_nz && !lead_seen && !last)
                    int_data = 8'h00;
                else
                    int_data = 8'h30 + {4'h0, dg};
                if (last)
                    state_next = CONV_T;
            end
            CONV_T: begin
                last = (int'(idx) == TIMER_W - 1);
                if (last)
                    state_next = WR_T;
            end
            WR_T: begin
                last     = (int'(idx) == TIMER_DIGITS - 1);
                bcd_sh   = bcd >> (4 * (TIMER_DIGITS - 1 - int'(idx)));
                dg       = bcd_sh[3:0];
                dig_nz   = sat_t || (dg != 4'h0);
                int_we   = 1'b1;
                int_addr = AW'(TIMER_ADDR + int'(idx));
                if (sat_t)
                    int_data = 8'h39;
                else if (BLANK_EN && !dig_nz && !lead_seen && !last)
                    int_data = 8'h00;
                else
                    int_data = 8'h30 + {4'h0, dg};
                if (last)
                    state_next = WR_L;
            end
            WR_L: begin
                int_we     = 1'b1;
                int_addr   = AW'(LIVES_ADDR);
                int_data   = 8'h30 + ((snap_lives > 4'd9) ? 8'd9 : {4'h0, snap_lives});
                state_next = WR_ST;
            end
            WR_ST: begin
                last     = (int'(idx) == 8);
                int_we   = 1'b1;
                int_addr = AW'(STATUS_ADDR + int'(idx));
                int_data = status_char(snap_win, snap_lose, int'(idx));
                if (last)
                    state_next = IDLE;
            end
            default:
                state_next = INIT;
        endcase
    end

    // Datapath: cell index, converter registers and input snapshot.
    // The timer conversion is loaded on the last score-digit write, so the
    // converter registers are shared by both fields.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx          <= '0;
            shreg        <= '0;
            bcd          <= '0;
            snap_score   <= '0;
            snap_counter <= '0;
            snap_lives   <= '0;
            snap_win     <= 1'b0;
            snap_lose    <= 1'b0;
            lead_seen    <= 1'b0;
        end else if (!we) begin
            case (state)
                INIT:
                    idx <= last ? '0 : idx + CW'(1);
                SNAP: begin
                    snap_score   <= score;
                    snap_counter <= counter;
                    snap_lives   <= lives;
                    snap_win     <= win;
                    snap_lose    <= lose;
                    shreg        <= MAXW'(score) << (MAXW - SCORE_W);
                    bcd          <= '0;
                    idx          <= '0;
                    lead_seen    <= 1'b0;
                end
                CONV_S, CONV_T: begin
                    bcd   <= dabble(bcd, shreg[MAXW-1]);
                    shreg <= shreg << 1;
                    idx   <= last ? '0 : idx + CW'(1);
                end
                WR_S: begin
                    if (last) begin
                        idx       <= '0;
                        shreg     <= MAXW'(snap_counter) << (MAXW - TIMER_W);
                        bcd       <= '0;
                        lead_seen <= 1'b0;
                    end else begin
                        idx       <= idx + CW'(1);
                        lead_seen <= lead_seen | dig_nz;
                    end
                end
                WR_T: begin
                    idx       <= last ? '0 : idx + CW'(1);
                    lead_seen <= lead_seen | dig_nz;
                end
                WR_L:
                    idx <= '0;
                WR_ST:
                    idx <= last ? '0 : idx + CW'(1);
                default: ;
            endcase
        end
    end

    // Single write port: the host wins. Host writes to addresses beyond
    // DEPTH are dropped.
    always_ff @(posedge Clk) begin
        if (we) begin
            if (int'(write_address) < DEPTH)
                mem[write_address] <= data_In;
        end else if (int_we) begin
            mem[int_addr] <= int_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            data_Out <= 8'h00;
        else if (int'(read_address) < DEPTH)
            data_Out <= mem[read_address];
        else
            data_Out <= 8'h00;
    end

endmodule

// File: doc/hud_text_ram.md
Name: hud_text_ram

Overview:
- Parametrised character buffer for the on-screen HUD text panel. Successor to the fixed score/lives/timer text memory.
- Holds a DEPTH x 8 ASCII array read by the text renderer through a registered read port.
- Owns the label text and the numeric and status fields. A sequential refresh engine replaces divide/modulo logic: an iterative double-dabble BCD converter feeds a digit writer that updates only on input change.
- External host write port retained.

Parameters:
- DEPTH, 160, character cells; address width AW = $clog2(DEPTH).
- SCORE_W, 10, score input width.
- SCORE_DIGITS, 3, score digits displayed.
- TIMER_W, 16, timer input width.
- TIMER_DIGITS, 3, timer digits displayed.
- SCORE_ADDR, 7, first score digit cell; label "Score:" plus 0x00 sits in the 7 cells before it.
- LIVES_ADDR, 32, lives digit cell; "Lives:" plus 0x00 sits before it.
- TIMER_ADDR, 87, first timer digit cell; "Timer:" plus 0x00 sits before it.
- STATUS_ADDR, 113, first of 9 status cells; "Status:" plus 0x00 sits before it.

Ports:
- Clk, input, 1, system clock.
- Reset_n, input, 1, asynchronous active-low reset.
- score, input, SCORE_W, binary score.
- counter, input, TIMER_W, binary timer.
- lives, input, 4, lives remaining.
- win, input, 1, game won.
- lose, input, 1, game lost.
- we, input, 1, host write enable.
- write_address, input, AW, host write cell.
- data_In, input, 8, host write data.
- read_address, input, AW, renderer read cell.
- data_Out, output, 8, registered read data.
- busy, output, 1, init or refresh in progress.

Behaviour:
- Reset (async, Reset_n low):
  - FSM goes to INIT, the cell index clears, and the snapshot registers clear.
  - data_Out = 0x00 and busy = 1.
  - Memory contents are don't-care until INIT completes.
- Read port: data_Out <= mem[read_address] on every clock, 1-cycle latency. A read and a write to the same cell in the same cycle returns the old data.
- Write arbitration (single write port):
  - Host we has priority.
  - When we is high, the FSM holds its state and all counters for that cycle; no internal write is lost.
- FSM states: INIT, IDLE, SNAP, CONV_S, WR_S, CONV_T, WR_T, WR_L, WR_ST.
- INIT:
  - Writes one cell per cycle, address 0..DEPTH-1.
  - Label cells get their ASCII; all other cells get 0x00.
  - Takes DEPTH cycles (plus host stalls), then goes to SNAP.
- IDLE:
  - busy = 0.
  - Goes to SNAP when {score, counter, lives, win, lose} differs from the snapshot.
- SNAP (1 cycle): latch all inputs into the snapshot and set busy = 1.
- CONV_S: double dabble, one input bit per cycle, SCORE_W cycles.
  - Saturation: if score > 10^SCORE_DIGITS - 1, all digits = 9.
- WR_S: SCORE_DIGITS cycles, MS digit first. Cell SCORE_ADDR+i <= 0x30 + digit.
- CONV_T and WR_T: same rules using counter and the TIMER_ parameters.
- WR_L (1 cycle): cell LIVES_ADDR <= 0x30 + min(lives, 9).
- WR_ST: 9 cycles, one character per cycle.
  - win: "Game Won" then 0x00.
  - lose and not win: "Game Over" then 0x00.
  - Neither: "Play!" then four 0x00.
  - win and lose both high: win takes priority.
- End of refresh: return to IDLE.
- Input changes during a refresh are ignored until IDLE; the change comparison in IDLE then triggers another refresh.
- Refresh latency without stalls is 1 + SCORE_W + SCORE_DIGITS + TIMER_W + TIMER_DIGITS + 1 + 9 cycles; with defaults, 43 cycles.
- Host writes to field or label cells are legal. They are overwritten at the next refresh or INIT.
- An out-of-range address (>= DEPTH, for non-power-of-2 DEPTH) is ignored on write and reads as 0x00.

Optional Feature:
- HUD_LEADING_BLANK_EN
  - Defined: leading zero digits of score and timer are written as 0x00. The least-significant digit is always shown, so value 0 displays as "  0".
  - Undefined: zero-padded digits, e.g. 0x30 0x30 0x37 for 7.

Test Plan:
- Reset, then run the full INIT with no host writes.
  - busy stays high for exactly 160 + 43 cycles.
  - Cells 0..5 read 0x53 0x63 0x6F 0x72 0x65 0x3A.
  - Cells 7..9 read 0x30 0x30 0x30.
  - Cell 200-beyond and unused cells read 0x00.
- score=742, counter=1234, lives=2, win=lose=0, wait for busy=0.
  - Cells 7..9 = "742".
  - Cells 87..89 = "999" (saturated).
  - Cell 32 = 0x32.
  - Cells 113..117 = "Play!".
- Hold we=1 for 5 cycles in the middle of CONV_S.
  - Refresh completes 5 cycles later.
  - Host cells hold the written data.
  - Score digits are still correct.
- Change score to 5 during WR_T.
  - Second refresh starts from IDLE.
  - Final cells 7..9 = "005", or 0x00 0x00 "5" with HUD_LEADING_BLANK_EN.
- win=1 and lose=1 together.
  - Cells 113..121 = "Game Won" then 0x00.
  - Then lose only: "Game Over".
- Assert Reset_n low mid-WR_S, then release.
  - data_Out = 0x00 immediately and busy = 1.
  - INIT reruns.
  - Final memory matches the current inputs.
